// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit geometry, add-3 adjust constants and converter state encoding.
// Also imported by the downstream single-digit BCD adder and its bench.
package bcd_pkg;

    localparam int unsigned BCD_DIG_W  = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StFinish = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIG_W-1:0] digit_in,
    output logic [BCD_DIG_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one shift per clock, with a
// start/done handshake. BCD_OUT/OVERFLOW update only when a conversion completes.
module bin_to_bcd_conv
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic [BIN_W-1:0]              BIN_IN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [BCD_DIG_W*DIGITS-1:0]   BCD_OUT,
    output logic                          OVERFLOW
);

    localparam int unsigned BCD_W = BCD_DIG_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_e       state_q;
    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  dig_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;

    logic [BCD_W-1:0]  dig_adj;
    logic [BCD_W-1:0]  dig_next;
    logic              ovf_next;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
        bcd_digit_adj u_adj (
            .digit_in  (dig_q[g*BCD_DIG_W +: BCD_DIG_W]),
            .digit_out (dig_adj[g*BCD_DIG_W +: BCD_DIG_W])
        );
    end

    // Shift the adjusted digits left, pulling in the binary MSB; the bit leaving
    // the top digit means the value no longer fits in DIGITS decimal digits.
    always_comb begin
        dig_next = {dig_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        ovf_next = ovf_q | dig_adj[BCD_W-1];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            bin_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            BCD_OUT  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        bin_q   <= BIN_IN;
                        dig_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        BUSY    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    bin_q <= bin_q << 1;
                    dig_q <= dig_next;
                    ovf_q <= ovf_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        BCD_OUT  <= dig_next;
                        OVERFLOW <= ovf_next;
                        DONE     <= 1'b1;
                        BUSY     <= 1'b0;
                        state_q  <= StFinish;
                    end
                end
                StFinish: begin
                    DONE    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Bench for bin_to_bcd_conv: a 3-digit and a 2-digit instance share the same stimulus;
// results are checked against a table of constants and a decimal arithmetic model.
module tb_bin_to_bcd_conv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    bin_to_bcd_conv #(.BIN_W(8), .DIGITS(3)) dut3 (
        .CLK      (clk),
        .RESET    (reset),
        .START    (start),
        .BIN_IN   (bin_in),
        .BUSY     (busy3),
        .DONE     (done3),
        .BCD_OUT  (bcd3),
        .OVERFLOW (ovf3)
    );

    bin_to_bcd_conv #(.BIN_W(8), .DIGITS(2)) dut2 (
        .CLK      (clk),
        .RESET    (reset),
        .START    (start),
        .BIN_IN   (bin_in),
        .BUSY     (busy2),
        .DONE     (done2),
        .BCD_OUT  (bcd2),
        .OVERFLOW (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp3;
        logic [7:0]  exp2;
        bit          exp_ovf2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Decimal reference: value mod 10^digits, one packed nibble per decimal digit.
    function automatic logic [11:0] model_bcd(int unsigned v, int unsigned digits);
        logic [11:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(digits); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit model_ovf(int unsigned v, int unsigned digits);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(digits); i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic convert(input logic [7:0] v, input logic [11:0] exp3, input logic [7:0] e2,
                           input bit e_ovf2, input string tag, output logic [11:0] r3);
        int busy_cnt;
        bit got;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'($urandom);
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done3) got = 1'b1;
            else begin
                if (busy3) busy_cnt++;
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, " busy low at done"}, 32'(busy3), 32'd0);
        check({tag, " bcd3"}, 32'(bcd3), 32'(exp3));
        check({tag, " ovf3"}, 32'(ovf3), 32'd0);
        check({tag, " done2 aligned"}, 32'(done2), 32'd1);
        check({tag, " bcd2"}, 32'(bcd2), 32'(e2));
        check({tag, " ovf2"}, 32'(ovf2), 32'(e_ovf2));
        r3 = bcd3;
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done3), 32'd0);
        check({tag, " bcd3 held"}, 32'(bcd3), 32'(exp3));
    endtask

    vec_t vecs[10];
    logic [11:0] res;
    logic [11:0] ra, rb;
    int unsigned vals[25];
    int ndone, k1, k2;
    logic [11:0] res1, res2;
    logic [4:0] s0, s1;
    logic c0, c1;

    initial begin
        vecs[0] = '{8'd0,   12'h000, 8'h00, 1'b0};
        vecs[1] = '{8'd255, 12'h255, 8'h55, 1'b1};
        vecs[2] = '{8'd99,  12'h099, 8'h99, 1'b0};
        vecs[3] = '{8'd9,   12'h009, 8'h09, 1'b0};
        vecs[4] = '{8'd123, 12'h123, 8'h23, 1'b1};
        vecs[5] = '{8'd100, 12'h100, 8'h00, 1'b1};
        vecs[6] = '{8'd1,   12'h001, 8'h01, 1'b0};
        vecs[7] = '{8'd128, 12'h128, 8'h28, 1'b1};
        vecs[8] = '{8'd200, 12'h200, 8'h00, 1'b1};
        vecs[9] = '{8'd67,  12'h067, 8'h67, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy3), 32'd0);
        check("reset done", 32'(done3), 32'd0);
        check("reset bcd3", 32'(bcd3), 32'd0);
        check("reset ovf3", 32'(ovf3), 32'd0);
        check("reset bcd2", 32'(bcd2), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            convert(vecs[i].bin, vecs[i].exp3, vecs[i].exp2, vecs[i].exp_ovf2,
                    $sformatf("vec%0d", i), res);
        end

        // Reset four cycles into a conversion of 200 aborts it without a DONE pulse.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(busy3), 32'd0);
        check("abort bcd3", 32'(bcd3), 32'd0);
        check("abort ovf3", 32'(ovf3), 32'd0);
        check("abort bcd2", 32'(bcd2), 32'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done3 || done2 || busy3) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);

        // START held high with BIN_IN changing every cycle.
        foreach (vals[i]) vals[i] = $urandom_range(0, 255);
        ndone = 0;
        k1 = -1;
        k2 = -1;
        res1 = '0;
        res2 = '0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done3) begin
                if (ndone == 0) begin k1 = k; res1 = bcd3; end
                else if (ndone == 1) begin k2 = k; res2 = bcd3; end
                ndone++;
            end
            start  = 1'b1;
            bin_in = 8'(vals[k]);
        end
        start = 1'b0;
        check("held first done cycle", 32'(k1), 32'd9);
        check("held first result", 32'(res1), 32'(model_bcd(vals[0], 3)));
        check("held second done cycle", 32'(k2), 32'd19);
        check("held second result", 32'(res2), 32'(model_bcd(vals[10], 3)));
        repeat (12) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            automatic int unsigned v = $urandom_range(0, 255);
            convert(8'(v), model_bcd(v, 3), model_bcd(v, 2)[7:0], model_ovf(v, 2),
                    $sformatf("rand%0d", i), res);
        end

        // Feed converted digits into a decimal digit adder with carry chained.
        convert(8'd45, 12'h045, 8'h45, 1'b0, "chain45", ra);
        convert(8'd54, 12'h054, 8'h54, 1'b0, "chain54", rb);
        s0 = 5'(ra[3:0]) + 5'(rb[3:0]);
        c0 = s0 > 5'd9;
        if (c0) s0 = s0 - 5'd10;
        s1 = 5'(ra[7:4]) + 5'(rb[7:4]) + 5'(c0);
        c1 = s1 > 5'd9;
        if (c1) s1 = s1 - 5'd10;
        check("chain 45+54", 32'({c1, s1[3:0], c0, s0[3:0]}), 32'({1'b0, 4'd9, 1'b0, 4'd9}));

        convert(8'd58, 12'h058, 8'h58, 1'b0, "chain58", ra);
        convert(8'd67, 12'h067, 8'h67, 1'b0, "chain67", rb);
        s0 = 5'(ra[3:0]) + 5'(rb[3:0]);
        c0 = s0 > 5'd9;
        if (c0) s0 = s0 - 5'd10;
        s1 = 5'(ra[7:4]) + 5'(rb[7:4]) + 5'(c0);
        c1 = s1 > 5'd9;
        if (c1) s1 = s1 - 5'd10;
        check("chain 58+67 digits", 32'({c1, s1[3:0], c0, s0[3:0]}),
              32'({1'b1, 4'd2, 1'b1, 4'd5}));
        check("chain 58+67 sum", 32'({3'b000, c1, s1[3:0], s0[3:0]}), 32'h125);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_conv.md
Name: bin_to_bcd_conv

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one shift per clock.
- Sits directly upstream of the single-digit BCD adder. It turns binary operands into packed BCD digits, and each 4-bit digit is then fed to the adder's A/B inputs.
- Start/done handshake; the result is held stable until the next conversion completes.

Parameters:
- BIN_W, 8, width of binary input; >= 1.
- DIGITS, 3, number of BCD output digits; BCD_OUT width = 4*DIGITS.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request conversion. Sampled only in IDLE.
- BIN_IN  input  BIN_W  unsigned binary value. Captured on the edge where START is accepted.
- BUSY  output  1  conversion in progress.
- DONE  output  1  one-cycle pulse; result valid.
- BCD_OUT  output  4*DIGITS  packed BCD, digit 0 = bits [3:0] (least significant).
- OVERFLOW  output  1  value exceeded 10^DIGITS-1. Valid with DONE, held with BCD_OUT.

Behaviour:
- Reset (RESET=1 at a CLK edge) overrides everything, including a conversion in progress:
  - state=IDLE;
  - BUSY=0, DONE=0, BCD_OUT=0, OVERFLOW=0;
  - internal shift register, scratch digits and counter cleared.
- States are IDLE, SHIFT and FINISH.
- IDLE:
  - START=1 at edge E0: load shift register with BIN_IN, clear scratch digits and sticky overflow, count=0, go to SHIFT.
  - BUSY=1 from E0.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3. All digits are adjusted in parallel, combinationally.
  - Then the {scratch digits, shift register} concatenation shifts left by 1.
  - The MSB of the shift register enters digit 0 bit 0.
  - A 1 shifted out of the top digit sets sticky overflow.
  - count increments. On the edge performing shift number BIN_W, go to FINISH.
  - That same edge registers the final digits into BCD_OUT and sticky overflow into OVERFLOW.
  - DONE=1 and BUSY=0 are registered on that same edge.
- FINISH:
  - Lasts exactly one cycle, DONE=1.
  - Next edge: DONE=0, go to IDLE.
  - START is ignored in FINISH.
- Latency: START accepted at E0 means DONE is high during the cycle after edge E0+BIN_W, i.e. BIN_W cycles after acceptance. Minimum START-to-START spacing is BIN_W+2 edges.
- START while BUSY or in FINISH is ignored; no queuing. BIN_IN changes after E0 have no effect.
- BCD_OUT/OVERFLOW change only on the completing edge or on reset. Intermediate scratch values are never visible.
- Overflow: BCD_OUT holds value mod 10^DIGITS and OVERFLOW=1. With DIGITS*4 >= BIN_W + ceil(BIN_W/3) overflow is impossible and OVERFLOW stays 0.
- Every digit of BCD_OUT is always in the range 0..9.
- BIN_W=1: a single SHIFT cycle. Correct result 0 or 1.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIG_W=4;
  - ADJ_THRESH=4'd5;
  - ADJ_ADD=4'd3;
  - the state encoding (IDLE, SHIFT, FINISH).
- The downstream BCD adder and its bench reuse the same package.
- Sub-module bcd_digit_adj: combinational, one 4-bit digit in, adjusted digit out (+3 if >= 5). Instantiated DIGITS times in a generate loop.

Test Plan:
- Defaults, BIN_IN=8'd0, START pulse -> DONE 8 cycles later; BCD_OUT=12'h000, OVERFLOW=0; BUSY high for exactly 8 cycles before DONE.
- BIN_IN=8'd255 -> BCD_OUT=12'h255. Then BIN_IN=8'd99 -> 12'h099. Then 8'd9 -> 12'h009. Check each DONE is a one-cycle pulse.
- START held high continuously with BIN_IN toggling each cycle:
  - only the value at the first accepted edge is converted;
  - the next conversion starts at the first IDLE edge after FINISH;
  - results match that sampled value.
- RESET asserted 4 cycles into a conversion of 8'd200 -> next cycle BUSY=0, BCD_OUT=0, OVERFLOW=0; no DONE pulse follows.
- DIGITS=2, BIN_IN=8'd123 -> BCD_OUT=8'h23, OVERFLOW=1. BIN_IN=8'd99 -> 8'h99, OVERFLOW=0.
- Chain to the BCD adder: convert 8'd45 and 8'd54, feed digit 0 and digit 1 with carry chained -> sums 9 and 9, both carries 0. Convert 8'd58 and 8'd67 -> digit sums 5 (carry 1) and 2 (carry 1), i.e. 125.
